// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence transmitter/detector family:
// FSM state encoding, default geometry and an even-parity helper.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } seq_state_e;

    localparam int   SEQ_PAT_W    = 3;
    localparam int   SEQ_GAP      = 2;
    localparam logic SEQ_IDLE_BIT = 1'b1;

    // Even parity of up to 32 bits; narrower vectors are zero-extended,
    // which leaves the parity unchanged.
    function automatic logic seq_even_parity(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/seq_piso.sv
// Parallel-load, MSB-first shift register. The shift is circular so the
// latched pattern is back in its load position after W shifts, which lets
// the transmitter resend copies without reloading.
module seq_piso #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] data_i,
    output logic         msb_o
);

    logic [W-1:0] sr_q, sr_d;

    // Load has priority over shift; hold otherwise.
    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = data_i;
        end else if (shift_i) begin
            sr_d = {sr_q[W-2:0], sr_q[W-1]};
        end
    end

    // Shift register storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign msb_o = sr_q[W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: latches a pattern on start and sends it
// MSB-first, rep+1 times, with GAP idle cycles between copies.
// Optional feature macro: SEQ_TX_PARITY_EN appends an even-parity bit to
// every copy.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | line at IDLE_BIT, waiting for start
// SEND    | pattern (or parity) bit of current copy on out
// GAP     | idle cycles between copies, busy still high
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int   PAT_W    = SEQ_PAT_W,
    parameter int   REP_W    = 4,
    parameter int   GAP      = SEQ_GAP,
    parameter logic IDLE_BIT = SEQ_IDLE_BIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [REP_W-1:0] rep,
    output logic             out,
    output logic             out_vld,
    output logic             busy,
    output logic             done
);

    localparam int BIT_CW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int GAP_CW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [BIT_CW-1:0] BIT_LAST = BIT_CW'(PAT_W - 1);

    seq_state_e        state_q, state_d;
    logic [BIT_CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [GAP_CW-1:0] gap_cnt_q, gap_cnt_d;
    logic [REP_W-1:0]  copy_q, copy_d;
    logic              out_q, out_d;
    logic              vld_q, vld_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              piso_load, piso_shift, piso_msb;
    logic              copy_end;
    logic [PAT_W-1:0]  load_pat;
`ifdef SEQ_TX_PARITY_EN
    logic              par_bit_q, par_bit_d;
    logic              par_ph_q, par_ph_d;
`endif

    // The first bit goes straight from pat_in to out at acceptance, so the
    // shifter is loaded pre-rotated: its MSB is always the next bit to send.
    assign load_pat = {pat_in[PAT_W-2:0], pat_in[PAT_W-1]};

    seq_piso #(
        .W (PAT_W)
    ) u_piso (
        .clk     (clk),
        .rst_n   (rst),
        .load_i  (piso_load),
        .shift_i (piso_shift),
        .data_i  (load_pat),
        .msb_o   (piso_msb)
    );

    // A copy ends on its last pattern bit, or on the parity bit when enabled.
`ifdef SEQ_TX_PARITY_EN
    assign copy_end = par_ph_q;
`else
    assign copy_end = (bit_cnt_q == BIT_LAST);
`endif

    // Next-state and registered-output values; defaults describe the idle line.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        copy_d     = copy_q;
        out_d      = IDLE_BIT;
        vld_d      = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        piso_load  = 1'b0;
        piso_shift = 1'b0;
`ifdef SEQ_TX_PARITY_EN
        par_bit_d  = par_bit_q;
        par_ph_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d   = ST_SEND;
                    piso_load = 1'b1;
                    bit_cnt_d = '0;
                    copy_d    = rep;
                    out_d     = pat_in[PAT_W-1];
                    vld_d     = 1'b1;
                    busy_d    = 1'b1;
`ifdef SEQ_TX_PARITY_EN
                    par_bit_d = seq_even_parity(32'(pat_in));
`endif
                end
            end
            ST_SEND: begin
                if (stop) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    gap_cnt_d = '0;
                    copy_d    = '0;
                end else if (copy_end) begin
                    bit_cnt_d = '0;
                    if (copy_q == '0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        copy_d = copy_q - 1'b1;
                        busy_d = 1'b1;
                        if (GAP > 0) begin
                            state_d   = ST_GAP;
                            gap_cnt_d = GAP_CW'(GAP - 1);
                        end else begin
                            out_d      = piso_msb;
                            vld_d      = 1'b1;
                            piso_shift = 1'b1;
                        end
                    end
`ifdef SEQ_TX_PARITY_EN
                end else if (bit_cnt_q == BIT_LAST) begin
                    par_ph_d = 1'b1;
                    out_d    = par_bit_q;
                    vld_d    = 1'b1;
                    busy_d   = 1'b1;
`endif
                end else begin
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    out_d      = piso_msb;
                    vld_d      = 1'b1;
                    busy_d     = 1'b1;
                    piso_shift = 1'b1;
                end
            end
            ST_GAP: begin
                if (stop) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    gap_cnt_d = '0;
                    copy_d    = '0;
                end else if (gap_cnt_q == '0) begin
                    state_d    = ST_SEND;
                    out_d      = piso_msb;
                    vld_d      = 1'b1;
                    busy_d     = 1'b1;
                    piso_shift = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                    busy_d    = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            copy_q    <= '0;
            out_q     <= IDLE_BIT;
            vld_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            copy_q    <= copy_d;
            out_q     <= out_d;
            vld_q     <= vld_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

`ifdef SEQ_TX_PARITY_EN
    // Parity of the latched pattern and the parity-cycle flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_bit_q <= 1'b0;
            par_ph_q  <= 1'b0;
        end else begin
            par_bit_q <= par_bit_d;
            par_ph_q  <= par_ph_d;
        end
    end
`endif

    assign out     = out_q;
    assign out_vld = vld_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
`timescale 1ns/1ps
module tb_seq_pattern_tx;

    localparam int   PAT_W    = 3;
    localparam int   REP_W    = 4;
    localparam int   GAP      = 2;
    localparam logic IDLE_BIT = 1'b1;
`ifdef SEQ_TX_PARITY_EN
    localparam int   L        = PAT_W + 1;
`else
    localparam int   L        = PAT_W;
`endif

    // Expected line state per cycle: {out, out_vld, busy, done}
    typedef logic [3:0] obs_t;
    localparam obs_t IDLE_V = {IDLE_BIT, 3'b000};

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [PAT_W-1:0] pat_in = '0;
    logic [REP_W-1:0] rep = '0;
    logic             out, out_vld, busy, done;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_done_cyc = -1;
    int   s0;
    obs_t exp_q[$];
    obs_t cur = IDLE_V;

    seq_pattern_tx #(
        .PAT_W    (PAT_W),
        .REP_W    (REP_W),
        .GAP      (GAP),
        .IDLE_BIT (IDLE_BIT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .pat_in  (pat_in),
        .rep     (rep),
        .out     (out),
        .out_vld (out_vld),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_line(input string tag);
        check_val({tag, ".out"},  32'(out),     32'(cur[3]));
        check_val({tag, ".vld"},  32'(out_vld), 32'(cur[2]));
        check_val({tag, ".busy"}, 32'(busy),    32'(cur[1]));
        check_val({tag, ".done"}, 32'(done),    32'(cur[0]));
    endtask

    // Whole transfer as a cycle list: rep+1 copies, GAP idles between them,
    // then the done cycle.
    task automatic expand(input logic [PAT_W-1:0] p, input int r);
        for (int c = 0; c <= r; c++) begin
            for (int i = PAT_W - 1; i >= 0; i--) exp_q.push_back({p[i], 3'b110});
`ifdef SEQ_TX_PARITY_EN
            exp_q.push_back({^p, 3'b110});
`endif
            if (c < r) begin
                for (int g = 0; g < GAP; g++) exp_q.push_back({IDLE_BIT, 3'b010});
            end
        end
        exp_q.push_back({IDLE_BIT, 3'b001});
    endtask

    task automatic model_edge();
        if (!rst) begin
            exp_q.delete();
            cur = IDLE_V;
        end else if (cur[1] && stop) begin
            exp_q.delete();
            cur = IDLE_V;
        end else if (!cur[1] && start && !stop) begin
            exp_q.delete();
            expand(pat_in, int'(rep));
            cur = exp_q.pop_front();
        end else if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
        end else begin
            cur = IDLE_V;
        end
    endtask

    // One clock: apply inputs, advance model on the edge, check 1 ns later.
    task automatic step(input string tag, input logic s, input logic sp,
                        input logic [PAT_W-1:0] p, input logic [REP_W-1:0] r);
        start  = s;
        stop   = sp;
        pat_in = p;
        rep    = r;
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        check_line(tag);
        if (done === 1'b1) last_done_cyc = cyc;
    endtask

    task automatic idle_steps(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 3'(i), 4'(i));
    endtask

    task automatic async_reset(input string tag, input int hold);
        #3;
        rst = 1'b0;
        exp_q.delete();
        cur = IDLE_V;
        #1;
        check_line(tag);
        for (int i = 0; i < hold; i++) step(tag, 1'b0, 1'b0, '0, '0);
        rst = 1'b1;
    endtask

    initial begin
        #1 rst = 1'b0;
        #1;
        check_line("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;

        // Single copy of 001.
        s0 = cyc;
        step("p001", 1'b1, 1'b0, 3'b001, 4'd0);
        idle_steps("p001", 5);
        check_val("p001.done_cyc", 32'(last_done_cyc - s0), 32'(L + 1));

        // Three copies with gaps.
        s0 = cyc;
        step("rep2", 1'b1, 1'b0, 3'b001, 4'd2);
        idle_steps("rep2", 3 * L + 2 * GAP + 2);
        check_val("rep2.done_cyc", 32'(last_done_cyc - s0), 32'(3 * L + 2 * GAP + 1));

        // Parity-relevant pattern, single copy.
        step("p011", 1'b1, 1'b0, 3'b011, 4'd0);
        idle_steps("p011", L + 1);

        // Abort at cycle 2, restart at cycle 3.
        last_done_cyc = -1;
        step("stop", 1'b1, 1'b0, 3'b001, 4'd1);
        step("stop", 1'b0, 1'b0, 3'b111, 4'd5);
        step("stop", 1'b0, 1'b1, 3'b111, 4'd5);
        check_val("stop.no_done", 32'(last_done_cyc), 32'hFFFF_FFFF);
        s0 = cyc;
        step("restart", 1'b1, 1'b0, 3'b101, 4'd0);
        idle_steps("restart", L + 2);
        check_val("restart.done_cyc", 32'(last_done_cyc - s0), 32'(L + 1));

        // start and stop together in IDLE: dropped.
        step("ss_idle", 1'b1, 1'b1, 3'b010, 4'd0);
        idle_steps("ss_idle", 2);

        // start held high, pattern/rep wiggling while busy.
        for (int i = 0; i < 16; i++) step("hold", 1'b1, 1'b0, 3'($urandom), (i % 4 == 0) ? 4'd0 : 4'($urandom));
        idle_steps("hold", 4 * L + 4 * GAP);

        // Asynchronous reset in the middle of SEND.
        step("arst", 1'b1, 1'b0, 3'b110, 4'd3);
        step("arst", 1'b0, 1'b0, 3'b110, 4'd3);
        async_reset("arst", 2);
        idle_steps("arst_post", 6);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset("rnd_rst", int'($urandom_range(0, 2)));
            end else begin
                step("rnd", ($urandom_range(0, 2) == 0), ($urandom_range(0, 24) == 0),
                     3'($urandom), 4'($urandom_range(0, 4)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter: latches a PAT_W-bit pattern on a start request and shifts it out MSB-first, one bit per clock, repeating it a programmable number of times with a fixed idle gap between copies. It is the transmit-side counterpart of the team's serial sequence detectors: it drives their `inp` input in bench and loopback configurations, and it serves as the stimulus source for on-chip self-test of detector paths.

## Interface
- `PAT_W`, default 3: pattern width in bits, ≥2.
- `REP_W`, default 4: width of the repeat-count input.
- `GAP`, default 2: idle cycles between consecutive copies, ≥0.
- `IDLE_BIT`, default 1'b1: line level driven whenever no pattern bit is being sent.

Ports:
- `clk`  in  1: clock; all logic is on the rising edge.
- `rst`  in  1: reset, asynchronous, active-low (0 = reset).
- `start`  in  1: request; sampled only in IDLE.
- `stop`  in  1: synchronous abort.
- `pat_in`  in  PAT_W: pattern; latched when start is accepted.
- `rep`  in  REP_W: copies to send minus one; latched when start is accepted.
- `out`  out  1: serial data (the detector's `inp`).
- `out_vld`  out  1: high while `out` carries a pattern bit or the parity bit.
- `busy`  out  1: high from the cycle after acceptance until the last bit.
- `done`  out  1: one-cycle pulse after normal completion.

## Operation
- Outputs are registered.
- Reset values: `out`=IDLE_BIT, `out_vld`=0, `busy`=0, `done`=0; state IDLE; counters 0.
- FSM states: IDLE, SEND, GAP.
  - IDLE: `start`=1 latches `pat_in` into the shift register and `rep` into the copy counter, clears the bit counter, then goes to SEND.
  - SEND: drives `pat[PAT_W-1-bit_cnt]` with `out_vld`=1. After bit PAT_W-1:
    - copies remain, GAP>0: go to GAP.
    - copies remain, GAP=0: stay in SEND and start the next copy with no bubble.
    - last copy: go to IDLE and pulse `done`.
  - GAP: drives `out`=IDLE_BIT, `out_vld`=0 for exactly GAP cycles, then returns to SEND.
- The copy counter decrements at the end of each copy. `rep`=N sends N+1 copies; `rep`=0 sends one copy.
- `start` while `busy` is ignored. `pat_in` and `rep` changes while busy have no effect.
- `stop`=1 in SEND or GAP: the next state is IDLE with outputs at their reset values and no `done`. `stop` takes priority over sequencing.
- `start` and `stop` both high in IDLE: `stop` wins and the request is dropped.
- The bit counter is `$clog2(PAT_W)` bits and the gap counter is `$clog2(GAP+1)` bits; neither wraps beyond its terminal value.

## Timing
- Latency: `start` is sampled at edge E0; the first bit appears on `out` after E0, with `busy`=1 and `out_vld`=1.
- One copy occupies PAT_W cycles, or PAT_W+1 with parity enabled.
- Total busy cycles = (rep+1)·L + rep·GAP, where L is the copy length.
- `done` is asserted in the cycle after the last bit. In that same cycle `busy`=0, `out`=IDLE_BIT and the FSM is in IDLE.
- `start` asserted in the `done` cycle is accepted, and its first bit follows on the next cycle (back-to-back transfers).
- `rst` falling at any time forces all outputs to reset values immediately, without waiting for `clk`. Release is synchronous in effect: the first active edge after `rst`=1 sees IDLE.

## Configuration
- `SEQ_TX_PARITY_EN` defined: each copy is followed by one even-parity bit (XOR of the latched pattern) with `out_vld`=1, so L=PAT_W+1. The parity cycle counts as part of the copy for GAP and `done` timing.
- Not defined: L=PAT_W, and no parity logic is generated.

## Structure
- Package `seq_pkg` holds:
  - the FSM state enum (IDLE, SEND, GAP, 2-bit);
  - the default localparams for PAT_W, GAP and IDLE_BIT, shared with the detector blocks;
  - a function for even parity.
- One natural sub-module: `seq_piso`, a parallel-load, MSB-first shift register with `load`/`shift` enables. The FSM and counters stay in the top module.

## Test plan
- Defaults, `pat_in`=3'b001, `rep`=0, `start` at cycle 0:
  - `out`=0,0,1 on cycles 1–3 with `out_vld`=1;
  - `done`=1 at cycle 4; `busy`=1 on cycles 1–3 only;
  - a downstream 001 detector asserts `det` in cycle 3.
- `rep`=2, GAP=2, `pat_in`=3'b001:
  - bits on cycles 1–3, 6–8 and 11–13;
  - `out`=1 with `out_vld`=0 on cycles 4–5 and 9–10;
  - `done` at cycle 14.
- `stop` at cycle 2 of a `rep`=1 transfer: cycle 3 shows `out`=1, `out_vld`=0, `busy`=0; `done` never rises. A new `start` at cycle 3 gives its first bit at cycle 4.
- `start` held high throughout with `rep`=0: transfers repeat with period 4 (3 bits plus the `done` cycle). Pulses during `busy` do not restart or corrupt the current copy.
- `rst` driven low mid-SEND (between edges): `out`=1 and `out_vld`/`busy`/`done`=0 immediately. After release, no bits are sent until a new `start`.
- With `SEQ_TX_PARITY_EN`, `pat_in`=3'b001, `rep`=0: `out`=0,0,1,1 on cycles 1–4; `done` at cycle 5. With `pat_in`=3'b011, the parity bit is 0.
